seq_mul8_initiator: RTL and testbench

Sequential shift-and-add 8x8 multiplier that drives the 16-bit add/sub unit as the initiator of its en/ready handshake. It holds A, B and c_in stable, raises en, waits for ready, captures the sum and releases. It accumulates one partial product per set multiplier bit. It sits in the ALU beside the adder and provides the MUL instruction without a combinational multiplier.

---
 rtl/seq_mul8_initiator_if.sv | 23 ++
 rtl/seq_mul8_initiator.sv | 164 ++++++++++++++++
 tb/tb_seq_mul8_initiator.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_mul8_initiator_if.sv
// Adder handshake bundle between the sequential multiplier (master) and the
// 16-bit add/sub unit (slave).
interface seq_mul8_initiator_if;
    localparam int unsigned SUM_W = 16;

    logic [SUM_W-1:0] add_a;
    logic [SUM_W-1:0] add_b;
    logic             add_cin;
    logic             add_en;
    logic [SUM_W-1:0] add_sum;
    logic             add_cout;
    logic             add_ready;

    modport master (
        output add_a, add_b, add_cin, add_en,
        input  add_sum, add_cout, add_ready
    );

    modport slave (
        input  add_a, add_b, add_cin, add_en,
        output add_sum, add_cout, add_ready
    );
endinterface

// File: rtl/seq_mul8_initiator.sv
// Shift-and-add 8x8 multiplier that borrows the shared 16-bit adder through
// an en/ready request, one adder transaction per set multiplier bit.
// Optional macro SIGNED_MUL_EN: two's-complement operands (sign-extended
// partial products, final partial product subtracted).
module seq_mul8_initiator (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  mcand,
    input  logic [7:0]  mplier,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    seq_mul8_initiator_if.master bus
);
    localparam int unsigned OP_W  = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned SUM_W = 2 * OP_W;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SCAN = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_REL  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OP_W - 1);

    logic [2:0]       state, state_nx;
    logic [OP_W-1:0]  mc, mc_nx;
    logic [OP_W-1:0]  mp, mp_nx;
    logic [SUM_W-1:0] acc, acc_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic             busy_nx, done_nx;
    logic [SUM_W-1:0] product_nx;
    logic [SUM_W-1:0] a_q, a_nx;
    logic [SUM_W-1:0] b_q, b_nx;
    logic             cin_q, cin_nx;
    logic             en_q, en_nx;

    logic [SUM_W-1:0] pp;
    logic             pp_cin;
    logic             unused_cout;

    // Partial product for the current bit index
`ifdef SIGNED_MUL_EN
    assign pp     = SUM_W'({{OP_W{mc[OP_W-1]}}, mc} << idx);
    assign pp_cin = (idx == IDX_LAST);
`else
    assign pp     = SUM_W'({{OP_W{1'b0}}, mc} << idx);
    assign pp_cin = 1'b0;
`endif

    // The product always fits in 16 bits, so the adder carry is never needed
    assign unused_cout = bus.add_cout;

    assign bus.add_a   = a_q;
    assign bus.add_b   = b_q;
    assign bus.add_cin = cin_q;
    assign bus.add_en  = en_q;

    // Next-state and next-output logic
    always_comb begin
        state_nx   = state;
        mc_nx      = mc;
        mp_nx      = mp;
        acc_nx     = acc;
        idx_nx     = idx;
        busy_nx    = busy;
        done_nx    = 1'b0;
        product_nx = product;
        a_nx       = a_q;
        b_nx       = b_q;
        cin_nx     = cin_q;
        en_nx      = en_q;

        case (state)
            S_IDLE: begin
                if (start) begin
                    mc_nx    = mcand;
                    mp_nx    = mplier;
                    acc_nx   = '0;
                    idx_nx   = '0;
                    busy_nx  = 1'b1;
                    state_nx = S_SCAN;
                end
            end
            S_SCAN: begin
                if (mp[idx]) begin
                    a_nx     = acc;
                    b_nx     = pp;
                    cin_nx   = pp_cin;
                    en_nx    = 1'b1;
                    state_nx = S_REQ;
                end else if (idx == IDX_LAST) begin
                    product_nx = acc;
                    done_nx    = 1'b1;
                    state_nx   = S_FIN;
                end else begin
                    idx_nx = idx + 1'b1;
                end
            end
            S_REQ: begin
                if (bus.add_ready) begin
                    acc_nx   = bus.add_sum;
                    en_nx    = 1'b0;
                    state_nx = S_REL;
                end
            end
            S_REL: begin
                // Wait for ready to drop so the next request sees a fresh ready
                if (!bus.add_ready) begin
                    if (idx == IDX_LAST) begin
                        product_nx = acc;
                        done_nx    = 1'b1;
                        state_nx   = S_FIN;
                    end else begin
                        idx_nx   = idx + 1'b1;
                        state_nx = S_SCAN;
                    end
                end
            end
            S_FIN: begin
                busy_nx  = 1'b0;
                state_nx = S_IDLE;
            end
            default: begin
                en_nx    = 1'b0;
                busy_nx  = 1'b0;
                state_nx = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            mc      <= '0;
            mp      <= '0;
            acc     <= '0;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state   <= state_nx;
            mc      <= mc_nx;
            mp      <= mp_nx;
            acc     <= acc_nx;
            idx     <= idx_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            product <= product_nx;
            a_q     <= a_nx;
            b_q     <= b_nx;
            cin_q   <= cin_nx;
            en_q    <= en_nx;
        end
    end
endmodule

// File: tb/tb_seq_mul8_initiator.sv
// Bench for seq_mul8_initiator: behavioural adder slave, product scoreboard,
// and request-count/operand-stability monitor.
module tb_seq_mul8_initiator;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  mcand;
    logic [7:0]  mplier;
    logic        busy;
    logic        done;
    logic [15:0] product;

    seq_mul8_initiator_if bus ();

    seq_mul8_initiator dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .busy    (busy),
        .done    (done),
        .product (product),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int k_cfg = 1;
    int r_cfg = 0;

    logic [15:0] exp_q[$];

    // Adder slave: ready rises k_cfg cycles into a request, held r_cfg cycles after en drops
    int req_cnt;
    int hold_cnt;
    always @(posedge clk) begin
        if (rst) begin
            bus.add_ready <= 1'b0;
            bus.add_sum   <= '0;
            bus.add_cout  <= 1'b0;
            req_cnt       <= 0;
            hold_cnt      <= 0;
        end else if (bus.add_en && !bus.add_ready) begin
            if (req_cnt >= k_cfg - 1) begin
                bus.add_ready <= 1'b1;
                {bus.add_cout, bus.add_sum} <= bus.add_cin ?
                    ({1'b0, bus.add_a} - {1'b0, bus.add_b}) :
                    ({1'b0, bus.add_a} + {1'b0, bus.add_b});
                req_cnt <= 0;
            end else begin
                req_cnt <= req_cnt + 1;
            end
        end else if (!bus.add_en && bus.add_ready) begin
            if (hold_cnt >= r_cfg) begin
                bus.add_ready <= 1'b0;
                hold_cnt      <= 0;
            end else begin
                hold_cnt <= hold_cnt + 1;
            end
        end else if (!bus.add_en) begin
            req_cnt <= 0;
        end
    end

    // Monitor: count requests, subtracting requests, and operand changes under en
    int req_total = 0;
    int cin_total = 0;
    int stab_err  = 0;
    logic        prev_en = 1'b0;
    logic [15:0] prev_a, prev_b;
    logic        prev_cin;
    always @(negedge clk) begin
        if (bus.add_en === 1'b1 && prev_en !== 1'b1) begin
            req_total = req_total + 1;
            if (bus.add_cin === 1'b1) cin_total = cin_total + 1;
        end
        if (bus.add_en === 1'b1 && prev_en === 1'b1 &&
            (bus.add_a !== prev_a || bus.add_b !== prev_b || bus.add_cin !== prev_cin))
            stab_err = stab_err + 1;
        prev_en  = bus.add_en;
        prev_a   = bus.add_a;
        prev_b   = bus.add_b;
        prev_cin = bus.add_cin;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] model_mul(input logic [7:0] a, input logic [7:0] b);
`ifdef SIGNED_MUL_EN
        return 16'($signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b}));
`else
        return 16'({8'd0, a} * {8'd0, b});
`endif
    endfunction

    function automatic int exp_cin_reqs(input logic [7:0] b);
`ifdef SIGNED_MUL_EN
        return int'(b[7]);
`else
        return 0;
`endif
    endfunction

    // One multiply through the scoreboard; optional stray start while busy
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input int k,
                           input int r, input bit mid, input logic [15:0] expv);
        int r0, c0, c;
        bit got;
        logic [15:0] popped;
        k_cfg = k;
        r_cfg = r;
        @(negedge clk);
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        exp_q.push_back(expv);
        r0 = req_total;
        c0 = cin_total;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mcand  = ~a;
        mplier = ~b;
        chk("busy_after_start", 32'(busy), 32'd1);
        c   = 0;
        got = 1'b0;
        while (!got && c < 2000) begin
            @(posedge clk);
            #1;
            c++;
            if (mid && c == 3) begin
                start  = 1'b1;
                mcand  = 8'hAA;
                mplier = 8'hFF;
            end else if (mid && c == 4) begin
                start = 1'b0;
            end
            if (done === 1'b1) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=none required=done within 2000 cycles");
        end else begin
            popped = exp_q.pop_front();
            chk("product", 32'(product), 32'(popped));
            chk("busy_in_done", 32'(busy), 32'd1);
            chk("req_count", 32'(req_total - r0), 32'($countones(b)));
            chk("cin_reqs", 32'(cin_total - c0), 32'(exp_cin_reqs(b)));
            if (b == 8'h00) chk("zero_latency", 32'(c), 32'd8);
            @(posedge clk);
            #1;
            chk("done_pulse", 32'(done), 32'd0);
            chk("busy_after_done", 32'(busy), 32'd0);
            chk("product_held", 32'(product), 32'(popped));
            if (mid) begin
                got = 1'b0;
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk);
                    #1;
                    if (done === 1'b1 || busy === 1'b1) got = 1'b1;
                end
                chk("stray_start_ignored", 32'(got), 32'd0);
            end
        end
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int          k;
        int          r;
        bit          mid;
        logic [15:0] expv;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int rises;
        logic pe;
        logic [7:0] ra, rb;

        vecs[0] = '{8'd13, 8'd11, 2, 0, 1'b0, 16'h008F};
`ifdef SIGNED_MUL_EN
        vecs[1] = '{8'hFF, 8'hFF, 1, 0, 1'b0, 16'h0001};
`else
        vecs[1] = '{8'hFF, 8'hFF, 1, 0, 1'b0, 16'hFE01};
`endif
        vecs[2] = '{8'h5A, 8'h00, 1, 0, 1'b0, 16'h0000};
        vecs[3] = '{8'd6,  8'd5,  1, 3, 1'b1, 16'd30};

        rst    = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_add_en", 32'(bus.add_en), 32'd0);
        chk("rst_add_a", 32'(bus.add_a), 32'd0);
        chk("rst_add_b", 32'(bus.add_b), 32'd0);
        chk("rst_add_cin", 32'(bus.add_cin), 32'd0);

        for (int i = 0; i < 4; i++)
            run_mul(vecs[i].a, vecs[i].b, vecs[i].k, vecs[i].r, vecs[i].mid, vecs[i].expv);

        // Reset during the second adder request of 13x11
        k_cfg = 2;
        r_cfg = 0;
        @(negedge clk);
        mcand  = 8'd13;
        mplier = 8'd11;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rises = 0;
        pe    = 1'b0;
        for (int c = 0; c < 200 && rises < 2; c++) begin
            @(posedge clk);
            #1;
            if (bus.add_en === 1'b1 && pe !== 1'b1) rises++;
            pe = bus.add_en;
        end
        chk("second_req_seen", 32'(rises), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_add_en", 32'(bus.add_en), 32'd0);
        chk("midrst_product", 32'(product), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        run_mul(8'd7, 8'd9, 2, 0, 1'b0, 16'd63);

`ifdef SIGNED_MUL_EN
        run_mul(8'hFD, 8'h05, 1, 0, 1'b0, 16'hFFF1);
        run_mul(8'h04, 8'h80, 2, 1, 1'b0, 16'hFE00);
`else
        run_mul(8'hFD, 8'h05, 1, 0, 1'b0, 16'h04F1);
        run_mul(8'h04, 8'h80, 2, 1, 1'b0, 16'h0200);
`endif

        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_mul(ra, rb, int'($urandom_range(1, 3)), int'($urandom_range(0, 2)),
                    1'b0, model_mul(ra, rb));
        end

        chk("operand_stability", 32'(stab_err), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
